ula_arbiter: RTL and testbench

Round-robin arbiter that shares a single ALU instance (ULA, 32-bit, 3-bit op code) between two independent requesters, e.g. the execute stage and a debug/address-generation unit. Each port presents operands over a valid/ready handshake. The winning request is evaluated in the same cycle and its result is registered into a per-port response slot, returned over a second valid/ready handshake. Saturating per-port grant counters expose utilisation.

---
 rtl/ula_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ula_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbiter.sv
// ula_arbiter: two requesters share one 32-bit ALU (ULA) through a
// round-robin arbiter. The winning request is evaluated combinationally
// and its result is captured in that port's response slot, which is
// drained over a valid/ready handshake. Saturating counters track how
// many requests each port has had accepted.

module ula_arbiter #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned RR_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [31:0]      resp_result0,
  output logic [31:0]      resp_result1,
  output logic [1:0]       resp_zero,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLTU = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } alu_op_e;

  localparam port_e            PRIO_INIT = (RR_INIT != 0) ? PORT1 : PORT0;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  port_e             prio;
  port_e             winner;
  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic              grant_any;

  logic [2:0]        alu_op;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [31:0]       alu_result;
  logic              alu_zero;

  logic [31:0]       slot_result [2];
  logic [CNT_W-1:0]  cnt [2];

  // A port may compete only if its response slot is empty or being drained
  // this cycle, so a full, stalled slot never blocks the other port.
  always_comb begin
    eligible = 2'b00;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = req_valid[i] & (~resp_valid[i] | resp_ready[i]);
    end
  end

  // Pick the winner: a lone eligible port wins outright, a tie goes to prio.
  // With nobody eligible the mux still points at prio so it has a defined
  // select, but the result is thrown away.
  always_comb begin
    winner    = prio;
    grant     = 2'b00;
    grant_any = 1'b0;
    unique case (eligible)
      2'b01: begin
        winner    = PORT0;
        grant     = 2'b01;
        grant_any = 1'b1;
      end
      2'b10: begin
        winner    = PORT1;
        grant     = 2'b10;
        grant_any = 1'b1;
      end
      2'b11: begin
        winner    = prio;
        grant     = (prio == PORT1) ? 2'b10 : 2'b01;
        grant_any = 1'b1;
      end
      default: begin
        winner    = prio;
        grant     = 2'b00;
        grant_any = 1'b0;
      end
    endcase
  end

  assign req_ready = grant;

  // Operand mux feeding the single shared ALU.
  always_comb begin
    alu_op = req_op0;
    alu_a  = req_a0;
    alu_b  = req_b0;
    if (winner == PORT1) begin
      alu_op = req_op1;
      alu_a  = req_a1;
      alu_b  = req_b1;
    end
  end

  // The ALU itself. Shifts look at all 32 bits of b, so any amount of 32 or
  // more flushes the operand to zero instead of wrapping the shift count.
  always_comb begin
    alu_result = 32'd0;
    unique case (alu_op_e'(alu_op))
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a + ~alu_b + 32'd1;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_SLTU: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
      OP_SLL:  alu_result = (alu_b[31:5] != 27'd0) ? 32'd0 : (alu_a << alu_b[4:0]);
      OP_SRL:  alu_result = (alu_b[31:5] != 27'd0) ? 32'd0 : (alu_a >> alu_b[4:0]);
      default: alu_result = 32'd0;
    endcase
  end

  assign alu_zero = (alu_result == 32'd0);

  // Round-robin pointer: hand priority to the other port after every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PRIO_INIT;
    end else if (grant_any) begin
      prio <= (winner == PORT1) ? PORT0 : PORT1;
    end
  end

  // Response slots: a grant refills the slot (even while it is being
  // consumed, giving back-to-back results), otherwise a consume empties it.
  // Data is left untouched when a slot empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid     <= 2'b00;
      resp_zero      <= 2'b00;
      slot_result[0] <= 32'd0;
      slot_result[1] <= 32'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          resp_valid[i]  <= 1'b1;
          resp_zero[i]   <= alu_zero;
          slot_result[i] <= alu_result;
        end else if (resp_valid[i] && resp_ready[i]) begin
          resp_valid[i]  <= 1'b0;
        end
      end
    end
  end

  assign resp_result0 = slot_result[0];
  assign resp_result1 = slot_result[1];

  // Per-port accept counters, pinned at all-ones once full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign grant_cnt0 = cnt[0];
  assign grant_cnt1 = cnt[1];

endmodule

// File: tb/tb_ula_arbiter.sv
// Testbench for ula_arbiter: a vector table drives the main instance
// (CNT_W=16, RR_INIT=0) through single requests, alternation, back-pressure
// and an op sweep; a second instance (CNT_W=2, RR_INIT=1) covers priority
// after reset and counter saturation. An asynchronous mid-cycle reset is
// checked at the end.

module tb_ula_arbiter;

  logic        clk;
  logic        rst_n;

  logic [1:0]  a_valid, a_ready, a_rv, a_rr, a_zero;
  logic [2:0]  a_op0, a_op1;
  logic [31:0] a_a0, a_b0, a_a1, a_b1, a_res0, a_res1;
  logic [15:0] a_cnt0, a_cnt1;

  logic [1:0]  b_valid, b_ready, b_rv, b_rr, b_zero;
  logic [2:0]  b_op0, b_op1;
  logic [31:0] b_a0, b_b0, b_a1, b_b1, b_res0, b_res1;
  logic [1:0]  b_cnt0, b_cnt1;

  int n_compared;
  int n_mismatched;

  ula_arbiter #(.CNT_W(16), .RR_INIT(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_valid), .req_ready(a_ready),
    .req_op0(a_op0), .req_op1(a_op1),
    .req_a0(a_a0), .req_b0(a_b0), .req_a1(a_a1), .req_b1(a_b1),
    .resp_valid(a_rv), .resp_ready(a_rr),
    .resp_result0(a_res0), .resp_result1(a_res1), .resp_zero(a_zero),
    .grant_cnt0(a_cnt0), .grant_cnt1(a_cnt1)
  );

  ula_arbiter #(.CNT_W(2), .RR_INIT(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_valid), .req_ready(b_ready),
    .req_op0(b_op0), .req_op1(b_op1),
    .req_a0(b_a0), .req_b0(b_b0), .req_a1(b_a1), .req_b1(b_b1),
    .resp_valid(b_rv), .resp_ready(b_rr),
    .resp_result0(b_res0), .resp_result1(b_res1), .resp_zero(b_zero),
    .grant_cnt0(b_cnt0), .grant_cnt1(b_cnt1)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  rr;
    logic [2:0]  op0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [2:0]  op1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_rv;
    logic [31:0] exp_res0;
    logic [31:0] exp_res1;
    logic [1:0]  exp_zero;
    logic [15:0] exp_cnt0;
    logic [15:0] exp_cnt1;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  localparam logic [2:0]  P1OP = 3'd6;
  localparam logic [31:0] P1A  = 32'd1;
  localparam logic [31:0] P1B  = 32'd4;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    a_valid = v.valid;
    a_rr    = v.rr;
    a_op0   = v.op0;
    a_a0    = v.a0;
    a_b0    = v.b0;
    a_op1   = v.op1;
    a_a1    = v.a1;
    a_b1    = v.b1;
  endtask

  task automatic fillVectors();
    // single request on port 0
    vecs[0]  = '{2'b01, 2'b11, 3'd0, 32'd5, 32'd7, P1OP, P1A, P1B, 2'b01, 2'b01, 32'd12, 32'd0, 2'b00, 16'd1, 16'd0};
    // both ports hammering with resp_ready=11: strict alternation
    vecs[1]  = '{2'b11, 2'b11, 3'd1, 32'd9, 32'd9, P1OP, P1A, P1B, 2'b10, 2'b10, 32'd0, 32'd16, 2'b00, 16'd1, 16'd1};
    vecs[2]  = '{2'b11, 2'b11, 3'd1, 32'd9, 32'd9, P1OP, P1A, P1B, 2'b01, 2'b01, 32'd0, 32'd0, 2'b01, 16'd2, 16'd1};
    vecs[3]  = '{2'b11, 2'b11, 3'd1, 32'd9, 32'd9, P1OP, P1A, P1B, 2'b10, 2'b10, 32'd0, 32'd16, 2'b00, 16'd2, 16'd2};
    vecs[4]  = '{2'b11, 2'b11, 3'd1, 32'd9, 32'd9, P1OP, P1A, P1B, 2'b01, 2'b01, 32'd0, 32'd0, 2'b01, 16'd3, 16'd2};
    // port 1 back-pressured: slot fills, then port 0 wins every cycle
    vecs[5]  = '{2'b11, 2'b01, 3'd1, 32'd9, 32'd9, P1OP, P1A, P1B, 2'b10, 2'b10, 32'd0, 32'd16, 2'b00, 16'd3, 16'd3};
    vecs[6]  = '{2'b11, 2'b01, 3'd1, 32'd9, 32'd9, P1OP, P1A, P1B, 2'b01, 2'b11, 32'd0, 32'd16, 2'b01, 16'd4, 16'd3};
    vecs[7]  = '{2'b11, 2'b01, 3'd0, 32'd3, 32'd4, P1OP, P1A, P1B, 2'b01, 2'b11, 32'd7, 32'd16, 2'b00, 16'd5, 16'd3};
    // resp_ready[1] rises: port 1 accepted at once, slot refilled without a bubble
    vecs[8]  = '{2'b11, 2'b11, 3'd0, 32'd3, 32'd4, P1OP, P1A, P1B, 2'b10, 2'b10, 32'd0, 32'd16, 2'b00, 16'd5, 16'd4};
    vecs[9]  = '{2'b11, 2'b11, 3'd0, 32'd3, 32'd4, P1OP, P1A, P1B, 2'b01, 2'b01, 32'd7, 32'd0, 2'b00, 16'd6, 16'd4};
    // op sweep on port 0
    vecs[10] = '{2'b01, 2'b11, 3'd0, ONES, 32'd1, P1OP, P1A, P1B, 2'b01, 2'b01, 32'd0, 32'd0, 2'b01, 16'd7, 16'd4};
    vecs[11] = '{2'b01, 2'b11, 3'd6, ONES, 32'd40, P1OP, P1A, P1B, 2'b01, 2'b01, 32'd0, 32'd0, 2'b01, 16'd8, 16'd4};
    vecs[12] = '{2'b01, 2'b11, 3'd7, ONES, 32'd40, P1OP, P1A, P1B, 2'b01, 2'b01, 32'd0, 32'd0, 2'b01, 16'd9, 16'd4};
    vecs[13] = '{2'b01, 2'b11, 3'd5, ONES, 32'd1, P1OP, P1A, P1B, 2'b01, 2'b01, 32'd0, 32'd0, 2'b01, 16'd10, 16'd4};
    vecs[14] = '{2'b01, 2'b11, 3'd4, ONES, ONES, P1OP, P1A, P1B, 2'b01, 2'b01, 32'd0, 32'd0, 2'b01, 16'd11, 16'd4};
    vecs[15] = '{2'b01, 2'b11, 3'd7, ONES, 32'd4, P1OP, P1A, P1B, 2'b01, 2'b01, 32'h0FFF_FFFF, 32'd0, 2'b00, 16'd12, 16'd4};
    vecs[16] = '{2'b01, 2'b11, 3'd5, 32'd3, 32'd5, P1OP, P1A, P1B, 2'b01, 2'b01, 32'd1, 32'd0, 2'b00, 16'd13, 16'd4};
    vecs[17] = '{2'b01, 2'b11, 3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, P1OP, P1A, P1B, 2'b01, 2'b01, 32'hF000_F000, 32'd0, 2'b00, 16'd14, 16'd4};
    vecs[18] = '{2'b01, 2'b11, 3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, P1OP, P1A, P1B, 2'b01, 2'b01, 32'hFFF0_FFF0, 32'd0, 2'b00, 16'd15, 16'd4};
    vecs[19] = '{2'b01, 2'b11, 3'd1, 32'd3, 32'd5, P1OP, P1A, P1B, 2'b01, 2'b01, 32'hFFFF_FFFE, 32'd0, 2'b00, 16'd16, 16'd4};
    vecs[20] = '{2'b01, 2'b11, 3'd6, 32'd1, 32'd31, P1OP, P1A, P1B, 2'b01, 2'b01, 32'h8000_0000, 32'd0, 2'b00, 16'd17, 16'd4};
    vecs[21] = '{2'b01, 2'b11, 3'd6, 32'd1, 32'd32, P1OP, P1A, P1B, 2'b01, 2'b01, 32'd0, 32'd0, 2'b01, 16'd18, 16'd4};
    // idle: slot holds, then drains, then resp_ready on an empty slot
    vecs[22] = '{2'b00, 2'b00, 3'd6, 32'd1, 32'd32, P1OP, P1A, P1B, 2'b00, 2'b01, 32'd0, 32'd0, 2'b01, 16'd18, 16'd4};
    vecs[23] = '{2'b00, 2'b01, 3'd6, 32'd1, 32'd32, P1OP, P1A, P1B, 2'b00, 2'b00, 32'd0, 32'd0, 2'b00, 16'd18, 16'd4};
    vecs[24] = '{2'b00, 2'b11, 3'd6, 32'd1, 32'd32, P1OP, P1A, P1B, 2'b00, 2'b00, 32'd0, 32'd0, 2'b00, 16'd18, 16'd4};
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    fillVectors();

    rst_n   = 1'b1;
    a_valid = 2'b00; a_rr = 2'b00;
    a_op0 = 3'd0; a_a0 = 32'd0; a_b0 = 32'd0;
    a_op1 = 3'd0; a_a1 = 32'd0; a_b1 = 32'd0;
    b_valid = 2'b00; b_rr = 2'b00;
    b_op0 = 3'd0; b_a0 = 32'd0; b_b0 = 32'd0;
    b_op1 = 3'd0; b_a1 = 32'd0; b_b1 = 32'd0;

    // reset state, including which port holds priority
    #1 rst_n = 1'b0;
    a_valid = 2'b11;
    b_valid = 2'b11;
    #2;
    checkOutput("rst a resp_valid", 32'(a_rv), 32'd0);
    checkOutput("rst a result0", a_res0, 32'd0);
    checkOutput("rst a result1", a_res1, 32'd0);
    checkOutput("rst a zero", 32'(a_zero), 32'd0);
    checkOutput("rst a cnt0", 32'(a_cnt0), 32'd0);
    checkOutput("rst a cnt1", 32'(a_cnt1), 32'd0);
    checkOutput("rst a prio ready", 32'(a_ready), 32'd1);
    checkOutput("rst b prio ready", 32'(b_ready), 32'd2);
    checkOutput("rst b resp_valid", 32'(b_rv), 32'd0);

    @(negedge clk);
    a_valid = 2'b00;
    b_valid = 2'b00;
    rst_n   = 1'b1;

    // table-driven main sequence
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d req_ready", i), 32'(a_ready), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d resp_valid", i), 32'(a_rv), 32'(vecs[i].exp_rv));
      checkOutput($sformatf("v%0d cnt0", i), 32'(a_cnt0), 32'(vecs[i].exp_cnt0));
      checkOutput($sformatf("v%0d cnt1", i), 32'(a_cnt1), 32'(vecs[i].exp_cnt1));
      if (vecs[i].exp_rv[0]) begin
        checkOutput($sformatf("v%0d result0", i), a_res0, vecs[i].exp_res0);
        checkOutput($sformatf("v%0d zero0", i), 32'(a_zero[0]), 32'(vecs[i].exp_zero[0]));
      end
      if (vecs[i].exp_rv[1]) begin
        checkOutput($sformatf("v%0d result1", i), a_res1, vecs[i].exp_res1);
        checkOutput($sformatf("v%0d zero1", i), 32'(a_zero[1]), 32'(vecs[i].exp_zero[1]));
      end
    end

    // fill both slots (prio is 1 after the sweep), then reset mid-cycle
    @(negedge clk);
    a_valid = 2'b11; a_rr = 2'b00;
    a_op0 = 3'd0; a_a0 = 32'd2; a_b0 = 32'd2;
    a_op1 = 3'd0; a_a1 = 32'd3; a_b1 = 32'd3;
    #1 checkOutput("fill ready p1", 32'(a_ready), 32'd2);
    @(posedge clk);
    @(negedge clk);
    #1 checkOutput("fill ready p0", 32'(a_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("fill resp_valid", 32'(a_rv), 32'd3);
    checkOutput("fill result0", a_res0, 32'd4);
    checkOutput("fill result1", a_res1, 32'd6);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async resp_valid", 32'(a_rv), 32'd0);
    checkOutput("async cnt0", 32'(a_cnt0), 32'd0);
    checkOutput("async cnt1", 32'(a_cnt1), 32'd0);
    checkOutput("async prio ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    a_valid = 2'b00;
    a_rr    = 2'b00;
    rst_n   = 1'b1;

    // counter saturation on the narrow instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b_valid = 2'b01; b_rr = 2'b11;
      b_op0 = 3'd0; b_a0 = 32'(i); b_b0 = 32'd1;
      @(posedge clk);
      #1;
      checkOutput($sformatf("sat%0d cnt0", i), 32'(b_cnt0), (i >= 2) ? 32'd3 : 32'(i + 1));
      checkOutput($sformatf("sat%0d result0", i), b_res0, 32'(i + 1));
    end
    @(negedge clk);
    b_valid = 2'b00;
    b_rr    = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
